// File: rtl/dice_turn_ctrl_if.sv
// rtl/dice_turn_ctrl_if.sv - signal bundle between players, dice block and display for dice_turn_ctrl
// Purpose: groups the button inputs, the dice roll/throw pair and the score/result
//          display outputs of the turn controller into one interface.
// Signals:
//   btn_p0, btn_p1  player roll buttons, active-high
//   dice_throw[2:0] current value from the dice block
//   dice_roll       drives the dice button input (high = rolling)
//   active_player   player whose turn it is
//   score0, score1  per-player scores, SCORE_W bits
//   result_valid    one-cycle pulse on capture; result[2:0] holds the captured throw
//   winner_valid    high from the winning capture until reset; winner = winning player
// Modports: slave = the controller, master = the environment driving it.
interface dice_turn_ctrl_if #(
  parameter int SCORE_W = 6
);
  logic               btn_p0;
  logic               btn_p1;
  logic [2:0]         dice_throw;
  logic               dice_roll;
  logic               active_player;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic               result_valid;
  logic [2:0]         result;
  logic               winner_valid;
  logic               winner;

  modport slave (
    input  btn_p0, btn_p1, dice_throw,
    output dice_roll, active_player, score0, score1,
    output result_valid, result, winner_valid, winner
  );

  modport master (
    output btn_p0, btn_p1, dice_throw,
    input  dice_roll, active_player, score0, score1,
    input  result_valid, result, winner_valid, winner
  );
endinterface

// File: rtl/dice_turn_ctrl.sv
// rtl/dice_turn_ctrl.sv - two-player turn controller for the electronic dice
// Purpose: grants the dice to the active player, holds dice_roll for at least
//          HOLD_MIN cycles, captures the settled throw, keeps saturating scores,
//          gives an extra turn on a six or an invalid throw, and declares a winner.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    dice_turn_ctrl_if.slave (buttons, dice_throw in; dice_roll, scores,
//          result/winner outputs, all registered)
// Parameters: TARGET (winning score), HOLD_MIN (1..255), SCORE_W (>= 3).
// Build option: DICE_DEBOUNCE_EN adds a 2-flop synchronizer plus a 3-cycle
//               stability debouncer on each button.
module dice_turn_ctrl #(
  parameter int TARGET   = 20,
  parameter int HOLD_MIN = 4,
  parameter int SCORE_W  = 6
) (
  input logic             clk,
  input logic             reset,
  dice_turn_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ROLL, S_SETTLE, S_CAPTURE, S_DONE
  } state_t;

  localparam int unsigned SCORE_MAX = (1 << SCORE_W) - 1;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_MIN - 1);
  localparam logic [7:0]  HOLD_SAT  = 8'(HOLD_MIN);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_roll_cnt, w_roll_cnt_nxt;
  logic               r_dice_roll, w_dice_roll_nxt;
  logic               r_active_player, w_active_nxt;
  logic [SCORE_W-1:0] r_score0, w_score0_nxt;
  logic [SCORE_W-1:0] r_score1, w_score1_nxt;
  logic               r_result_valid, w_result_valid_nxt;
  logic [2:0]         r_result, w_result_nxt;
  logic               r_winner_valid, w_winner_valid_nxt;
  logic               r_winner, w_winner_nxt;

  logic [1:0]         w_btn_raw;
  logic [1:0]         w_btn;
  logic               w_btn_sel;
  logic [SCORE_W-1:0] w_cur_score;
  logic [SCORE_W-1:0] w_new_score;
  logic [31:0]        w_sum;
  logic               w_throw_ok;
  logic               w_win;

  assign w_btn_raw = {bus.btn_p1, bus.btn_p0};

`ifdef DICE_DEBOUNCE_EN
  logic [1:0] r_sync1, r_sync2, r_deb;
  logic [1:0] r_stab_cnt [2];

  // The debounced level follows the synchronized one only after it has
  // differed for three consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 2; i++) r_stab_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_stab_cnt[i] <= '0;
        end else if (r_stab_cnt[i] == 2'd2) begin
          r_deb[i]      <= r_sync2[i];
          r_stab_cnt[i] <= '0;
        end else begin
          r_stab_cnt[i] <= r_stab_cnt[i] + 2'd1;
        end
      end
    end
  end

  assign w_btn = r_deb;
`else
  assign w_btn = w_btn_raw;
`endif

  // Only the active player's button is ever looked at.
  assign w_btn_sel = r_active_player ? w_btn[1] : w_btn[0];

  // Score after the capture currently being made; invalid throws leave it alone.
  always_comb begin
    w_cur_score = r_active_player ? r_score1 : r_score0;
    w_throw_ok  = (bus.dice_throw != 3'd0) && (bus.dice_throw != 3'd7);
    w_sum       = 32'(w_cur_score) + 32'(bus.dice_throw);
    if (!w_throw_ok)
      w_new_score = w_cur_score;
    else if (w_sum > SCORE_MAX)
      w_new_score = SCORE_W'(SCORE_MAX);
    else
      w_new_score = SCORE_W'(w_sum);
    w_win = 32'(w_new_score) >= 32'(TARGET);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_btn_sel) w_state_nxt = S_ROLL;
      S_ROLL:    if (!w_btn_sel && (r_roll_cnt >= HOLD_LAST)) w_state_nxt = S_SETTLE;
      S_SETTLE:  w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = w_win ? S_DONE : S_IDLE;
      S_DONE:    w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; dice_roll is registered from the
  // next state so it is high exactly during ROLL cycles.
  always_comb begin
    w_roll_cnt_nxt     = r_roll_cnt;
    w_dice_roll_nxt    = (w_state_nxt == S_ROLL);
    w_active_nxt       = r_active_player;
    w_score0_nxt       = r_score0;
    w_score1_nxt       = r_score1;
    w_result_valid_nxt = 1'b0;
    w_result_nxt       = r_result;
    w_winner_valid_nxt = r_winner_valid;
    w_winner_nxt       = r_winner;
    case (r_state)
      S_IDLE: w_roll_cnt_nxt = '0;
      S_ROLL: if (r_roll_cnt < HOLD_SAT) w_roll_cnt_nxt = r_roll_cnt + 8'd1;
      S_CAPTURE: begin
        w_result_nxt       = bus.dice_throw;
        w_result_valid_nxt = 1'b1;
        if (r_active_player) w_score1_nxt = w_new_score;
        else                 w_score0_nxt = w_new_score;
        if (w_win) begin
          w_winner_nxt       = r_active_player;
          w_winner_valid_nxt = 1'b1;
        end else if (w_throw_ok && (bus.dice_throw != 3'd6)) begin
          w_active_nxt = ~r_active_player;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_roll_cnt      <= '0;
      r_dice_roll     <= 1'b0;
      r_active_player <= 1'b0;
      r_score0        <= '0;
      r_score1        <= '0;
      r_result_valid  <= 1'b0;
      r_result        <= '0;
      r_winner_valid  <= 1'b0;
      r_winner        <= 1'b0;
    end else begin
      r_roll_cnt      <= w_roll_cnt_nxt;
      r_dice_roll     <= w_dice_roll_nxt;
      r_active_player <= w_active_nxt;
      r_score0        <= w_score0_nxt;
      r_score1        <= w_score1_nxt;
      r_result_valid  <= w_result_valid_nxt;
      r_result        <= w_result_nxt;
      r_winner_valid  <= w_winner_valid_nxt;
      r_winner        <= w_winner_nxt;
    end
  end

  assign bus.dice_roll     = r_dice_roll;
  assign bus.active_player = r_active_player;
  assign bus.score0        = r_score0;
  assign bus.score1        = r_score1;
  assign bus.result_valid  = r_result_valid;
  assign bus.result        = r_result;
  assign bus.winner_valid  = r_winner_valid;
  assign bus.winner        = r_winner;
endmodule
